hazard_fwd_unit: RTL

- Parametrised hazard-detection and forwarding controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB). It closes the gap left by the free-running pipeline registers, which have no interlocks.
- Keeps its own shadow pipeline of register-usage metadata for the EX, MEM and WB stages.
- Generates PC/ID stall, ID/EX flush, EX operand-forward selects and ID write-back bypass selects.
- Keeps saturating stall and flush event counters.

---
 rtl/hazard_fwd_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control for the 5-stage RV32 pipeline.
// Tracks register usage of EX/MEM/WB in a shadow pipeline; all controls are combinational from it.
module hazard_fwd_unit #(
  parameter int unsigned RAWIDTH   = 5,
  parameter bit          FWD_EN    = 1'b1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [RAWIDTH-1:0]   id_rs1,
  input  logic [RAWIDTH-1:0]   id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [RAWIDTH-1:0]   id_rd,
  input  logic                 id_reg_we,
  input  logic                 id_is_load,
  input  logic                 ex_redirect,
  output logic                 stall_pc,
  output logic                 flush_id,
  output logic                 flush_ex,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic                 id_byp_a,
  output logic                 id_byp_b,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  logic               ex_valid_q, ex_use1_q, ex_use2_q, ex_we_q, ex_load_q;
  logic [RAWIDTH-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic               mem_valid_q, mem_we_q, mem_load_q;
  logic [RAWIDTH-1:0] mem_rd_q;
  logic               wb_valid_q, wb_we_q, wb_load_q;
  logic [RAWIDTH-1:0] wb_rd_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic               ex_valid_d;

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic wmatch(input logic v, input logic we,
                                  input logic [RAWIDTH-1:0] rd,
                                  input logic [RAWIDTH-1:0] src,
                                  input logic use_src);
    return v & we & (rd != '0) & (rd == src) & use_src;
  endfunction

  logic id_u1, id_u2;
  logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic load_use, interlock, stall_cond;
  logic fm_a, fm_b, fw_a, fw_b;

  assign id_u1  = id_valid & id_use_rs1;
  assign id_u2  = id_valid & id_use_rs2;
  assign ex_m1  = wmatch(ex_valid_q,  ex_we_q,  ex_rd_q,  id_rs1, id_u1);
  assign ex_m2  = wmatch(ex_valid_q,  ex_we_q,  ex_rd_q,  id_rs2, id_u2);
  assign mem_m1 = wmatch(mem_valid_q, mem_we_q, mem_rd_q, id_rs1, id_u1);
  assign mem_m2 = wmatch(mem_valid_q, mem_we_q, mem_rd_q, id_rs2, id_u2);
  assign wb_m1  = wmatch(wb_valid_q,  wb_we_q,  wb_rd_q,  id_rs1, id_u1);
  assign wb_m2  = wmatch(wb_valid_q,  wb_we_q,  wb_rd_q,  id_rs2, id_u2);

  assign load_use   = FWD_EN & ex_load_q & (ex_m1 | ex_m2);
  assign interlock  = !FWD_EN & (ex_m1 | ex_m2 | mem_m1 | mem_m2);
  assign stall_cond = load_use | interlock;

  // A redirect squashes the stalled ID instruction, so it wins over the stall.
  assign stall_pc = stall_cond & !ex_redirect;
  assign flush_id = ex_redirect;
  assign flush_ex = stall_pc | ex_redirect;
  assign id_byp_a = wb_m1;
  assign id_byp_b = wb_m2;

  assign fm_a = wmatch(mem_valid_q & !mem_load_q, mem_we_q, mem_rd_q, ex_rs1_q, ex_valid_q & ex_use1_q);
  assign fm_b = wmatch(mem_valid_q & !mem_load_q, mem_we_q, mem_rd_q, ex_rs2_q, ex_valid_q & ex_use2_q);
  assign fw_a = wmatch(wb_valid_q, wb_we_q, wb_rd_q, ex_rs1_q, ex_valid_q & ex_use1_q);
  assign fw_b = wmatch(wb_valid_q, wb_we_q, wb_rd_q, ex_rs2_q, ex_valid_q & ex_use2_q);

  assign fwd_a = !FWD_EN ? 2'b00 : fm_a ? 2'b01 : fw_a ? 2'b10 : 2'b00;
  assign fwd_b = !FWD_EN ? 2'b00 : fm_b ? 2'b01 : fw_b ? 2'b10 : 2'b00;

  assign ex_valid_d  = id_valid & !stall_pc & !ex_redirect;
  assign stall_cnt_d = (stall_pc && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  assign flush_cnt_d = (ex_redirect && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_use1_q   <= 1'b0;
      ex_use2_q   <= 1'b0;
      ex_rd_q     <= '0;
      ex_we_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_load_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_we_q     <= 1'b0;
      wb_load_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rs1_q    <= id_rs1;
      ex_rs2_q    <= id_rs2;
      ex_use1_q   <= id_use_rs1;
      ex_use2_q   <= id_use_rs2;
      ex_rd_q     <= id_rd;
      ex_we_q     <= id_reg_we;
      ex_load_q   <= id_is_load;
      mem_valid_q <= ex_valid_q;
      mem_rd_q    <= ex_rd_q;
      mem_we_q    <= ex_we_q;
      mem_load_q  <= ex_load_q;
      wb_valid_q  <= mem_valid_q;
      wb_rd_q     <= mem_rd_q;
      wb_we_q     <= mem_we_q;
      wb_load_q   <= mem_load_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
